rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Register-file write-port arbiter and pending-write scoreboard. Shares the single register-file write port (wren / write address / write data) among NREQ writeback requesters (ALU writeback, load unit, multi-cycle units) using round-robin arbitration with valid/ready handshakes. Tracks destination registers reserved at issue so decode can stall on read-after-write hazards. Sits between the execute/writeback units and the register file.

## Interface
Parameters:
- NREQ, 2, number of writeback requesters (2..8)
- XLEN, 32, data width
- AW, 5, register address width (32 registers)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*AW  destination of requester i, packed, slice i at [i*AW +: AW]
- req_data  in  NREQ*XLEN  write data of requester i, packed likewise
- req_ready  out  NREQ  grant; a write transfers when req_valid[i] && req_ready[i]
- rsv_valid  in  1  issue stage reserves a destination this cycle
- rsv_addr  in  AW  destination being reserved
- rs1_addr  in  AW  decode source 1
- rs2_addr  in  AW  decode source 2
- hazard  out  1  decode must stall: a source has an outstanding write
- rf_wren  out  1  register-file write enable, registered
- rf_waddr  out  AW  register-file write address, registered
- rf_wdata  out  XLEN  register-file write data, registered

## Operation
- Arbitration: combinational round-robin. rr_ptr (log2 NREQ bits) names the highest-priority requester; priority descends i = rr_ptr, rr_ptr+1, … modulo NREQ. At most one req_ready bit is high, and only for a valid requester. No requester valid -> req_ready = 0.
- rr_ptr update: on a transfer from requester g, rr_ptr <= (g+1) mod NREQ; otherwise it holds.
- Requesters hold valid/addr/data stable until transfer; the block does not check this.
- Output stage: every cycle, rf_wren <= transfer && (granted addr != 0); rf_waddr/rf_wdata <= granted addr/data on a transfer, else hold. The register file always accepts, so the output stage never back-pressures.
- x0: a transfer to address 0 completes the handshake but never asserts rf_wren. Reservations of address 0 are ignored.
- Scoreboard: pending[31:0], bit 0 constant 0. Set at the edge where rsv_valid && rsv_addr != 0. Cleared at the edge where a transfer to that address occurs.
- Simultaneous set and clear of the same address: set wins, so a newer reservation survives the retiring older write.
- Hazard (combinational): for each of rs1/rs2, the address is nonzero and either pending[rs] or (rf_wren && rf_waddr == rs). The output-stage term covers the cycle between acceptance and the actual register-file write.
- Writes with no prior reservation are legal and do not affect pending.

## Timing
- Reset (asynchronous assert): pending = 0, rr_ptr = 0, rf_wren = 0, rf_waddr = 0, rf_wdata = 0. req_ready and hazard follow combinationally from inputs and the cleared state.
- Reset mid-operation: any in-flight output-stage write is dropped and all reservations are lost.
- Latency: a transfer at edge k gives rf_wren high during cycle k..k+1; the register file captures the write at edge k+1.
- hazard for a source deasserts in the cycle after the register-file write edge.
- Throughput: one write per cycle. A continuously valid requester is granted at least once every NREQ transfers.

## Structure
- Shared package rv_pkg holds XLEN, AW, and NUM_REGS = 32. These constants are shared with the register file and decode.
- One sub-module, rr_arbiter (parameter N): inputs are the request vector and pointer; outputs are a one-hot grant and the grant index. The scoreboard and output stage are kept in rf_wb_arbiter.

## Test plan
- Reset, then drive req0 only with addr 5 and data 0xDEADBEEF -> req_ready = 01; next cycle rf_wren = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF; following cycle rf_wren = 0.
- NREQ = 2, both requesters valid for 4 cycles with distinct addresses -> grant sequence 0, 1, 0, 1; each ready bit is held high only on the transfer cycle.
- rsv_valid with addr 7, then rs1_addr = 7 -> hazard = 1 until req1 writes addr 7. hazard stays 1 through the output-stage cycle and clears one cycle after rf_wren.
- Same-cycle rsv_addr = 9 and transfer to addr 9 -> pending[9] remains 1 and hazard on rs2 = 9 stays asserted.
- Transfer to addr 0 with data 0x1234 -> handshake completes and rf_wren stays 0. rsv_addr = 0 then rs1 = 0 -> hazard = 0.
- Assert rst low mid-stream with pending[3] set and rf_wren = 1 -> all outputs 0 immediately, pending cleared; after release, req1 is granted first only if req0 is idle.

Source files
------------

// File: rtl/rv_pkg.sv
// Constants shared by the register file, decode and the writeback arbiter.
// Also provides a pointer-width helper that stays legal for a single requester.
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus, reservation/hazard port and register-file write port.
// The arbiter takes the slave side; the requesters, decode and the register file take the master side.
interface rf_wb_arbiter_if #(
    parameter int NREQ = 2,
    parameter int XLEN = rv_pkg::XLEN,
    parameter int AW   = rv_pkg::AW
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;

    logic                 rsv_valid;
    logic [AW-1:0]        rsv_addr;
    logic [AW-1:0]        rs1_addr;
    logic [AW-1:0]        rs2_addr;
    logic                 hazard;

    logic                 rf_wren;
    logic [AW-1:0]        rf_waddr;
    logic [XLEN-1:0]      rf_wdata;

    modport slave (
        input  req_valid, req_addr, req_data,
        input  rsv_valid, rsv_addr, rs1_addr, rs2_addr,
        output req_ready, hazard,
        output rf_wren, rf_waddr, rf_wdata
    );

    modport master (
        output req_valid, req_addr, req_data,
        output rsv_valid, rsv_addr, rs1_addr, rs2_addr,
        input  req_ready, hazard,
        input  rf_wren, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: ptr names the highest-priority requester,
// and priority then descends modulo N. The outputs are a one-hot grant and its index.
module rr_arbiter
    import rv_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port among NREQ writeback units and
// tracks reserved destinations so decode can stall on read-after-write hazards.
module rf_wb_arbiter
    import rv_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = rv_pkg::XLEN,
    parameter int AW   = rv_pkg::AW
) (
    input  logic             clk,
    input  logic             rst,
    rf_wb_arbiter_if.slave   bus
);

    localparam int PW = idx_width(NREQ);

    logic [NREQ-1:0]     grant;
    logic [PW-1:0]       gidx;
    logic [PW-1:0]       rr_ptr;
    logic                xfer;
    logic [AW-1:0]       g_addr;
    logic [XLEN-1:0]     g_data;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pend_nxt;
    logic                wren;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic                hit1;
    logic                hit2;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx)
    );

    assign xfer          = |grant;
    assign bus.req_ready = grant;

    always_comb begin
        g_addr = '0;
        g_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_addr = bus.req_addr[i*AW +: AW];
                g_data = bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            if (gidx == PW'(NREQ - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= gidx + 1'b1;
        end
    end

    // The set is applied after the clear so a new reservation outlives the older write retiring now.
    always_comb begin
        pend_nxt = pending;
        if (xfer)
            pend_nxt[g_addr] = 1'b0;
        if (bus.rsv_valid && (bus.rsv_addr != '0))
            pend_nxt[bus.rsv_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pending <= '0;
        else
            pending <= pend_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wren  <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            wren <= xfer && (g_addr != '0);
            if (xfer) begin
                waddr <= g_addr;
                wdata <= g_data;
            end
        end
    end

    assign bus.rf_wren  = wren;
    assign bus.rf_waddr = waddr;
    assign bus.rf_wdata = wdata;

    // The output-stage term covers the cycle between acceptance and the register-file write.
    assign hit1 = (bus.rs1_addr != '0) &&
                  (pending[bus.rs1_addr] || (wren && (waddr == bus.rs1_addr)));
    assign hit2 = (bus.rs2_addr != '0) &&
                  (pending[bus.rs2_addr] || (wren && (waddr == bus.rs2_addr)));
    assign bus.hazard = hit1 || hit2;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios pinned with literal values, then
// randomized traffic checked every cycle against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int NREQ = 2;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) bus ();

    rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: set of pending registers, priority pointer, pending RF write.
    bit [31:0]     m_pend   = '0;
    int            m_ptr    = 0;
    bit            m_wren   = 1'b0;
    bit [AW-1:0]   m_waddr  = '0;
    bit [XLEN-1:0] m_wdata  = '0;
    int            m_last_g = -1;

    function automatic int exp_grant();
        for (int k = 0; k < NREQ; k++)
            if (bus.req_valid[(m_ptr + k) % NREQ] === 1'b1)
                return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic bit exp_hit(input logic [AW-1:0] rs);
        if (rs == 0) return 1'b0;
        return m_pend[rs] || (m_wren && (m_waddr == rs));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend   = '0;
            m_ptr    = 0;
            m_wren   = 1'b0;
            m_waddr  = '0;
            m_wdata  = '0;
            m_last_g = -1;
        end else begin : upd
            int          g;
            bit [AW-1:0] a;
            g        = exp_grant();
            m_last_g = g;
            if (g >= 0) begin
                a       = bus.req_addr[g*AW +: AW];
                m_wren  = (a != 0);
                m_waddr = a;
                m_wdata = bus.req_data[g*XLEN +: XLEN];
                m_pend[a] = 1'b0;
                m_ptr   = (g + 1) % NREQ;
            end else begin
                m_wren = 1'b0;
            end
            if (bus.rsv_valid && (bus.rsv_addr != 0))
                m_pend[bus.rsv_addr] = 1'b1;
            m_pend[0] = 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        int              g;
        logic [NREQ-1:0] er;
        g  = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("m_req_ready", 64'(bus.req_ready), 64'(er));
        check("m_hazard",    64'(bus.hazard),
              64'(exp_hit(bus.rs1_addr) || exp_hit(bus.rs2_addr)));
        check("m_rf_wren",   64'(bus.rf_wren),  64'(m_wren));
        check("m_rf_waddr",  64'(bus.rf_waddr), 64'(m_waddr));
        check("m_rf_wdata",  64'(bus.rf_wdata), 64'(m_wdata));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.req_valid[i]            = v;
        bus.req_addr[i*AW +: AW]    = a;
        bus.req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = '0;
        bus.rs1_addr  = '0;
        bus.rs2_addr  = '0;
        #1 rst = 1'b0;
        #3;
        check("rst_wren",  64'(bus.rf_wren),   64'd0);
        check("rst_waddr", 64'(bus.rf_waddr),  64'd0);
        check("rst_wdata", 64'(bus.rf_wdata),  64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_hazard", 64'(bus.hazard),   64'd0);
        tick();
        rst = 1'b1;

        // single write from req0
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #2 check("t1_ready", 64'(bus.req_ready), 64'b01);
        tick();
        set_req(0, 1'b0, 5'd5, 32'hDEADBEEF);
        #2;
        check("t1_wren",  64'(bus.rf_wren),  64'd1);
        check("t1_waddr", 64'(bus.rf_waddr), 64'd5);
        check("t1_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
        tick();
        check("t1_wren_off", 64'(bus.rf_wren), 64'd0);

        // alternating grants with both requesters busy
        do_reset();
        set_req(0, 1'b1, 5'd10, 32'h100);
        set_req(1, 1'b1, 5'd20, 32'h200);
        for (int c = 0; c < 4; c++) begin
            #2 check("t2_grant", 64'(bus.req_ready), (c % 2 == 0) ? 64'b01 : 64'b10);
            tick();
            if (c % 2 == 0) set_req(0, 1'b1, 5'd11, 32'h101);
            else            set_req(1, 1'b1, 5'd21, 32'h201);
        end
        bus.req_valid = '0;
        tick();
        tick();

        // reservation of 7, retired by req1
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd7;
        tick();
        bus.rsv_valid = 1'b0;
        bus.rs1_addr  = 5'd7;
        #2 check("t3_hz_pend", 64'(bus.hazard), 64'd1);
        tick();
        set_req(1, 1'b1, 5'd7, 32'h77);
        #2;
        check("t3_ready", 64'(bus.req_ready), 64'b10);
        check("t3_hz_xfer", 64'(bus.hazard), 64'd1);
        tick();
        set_req(1, 1'b0, 5'd7, 32'h77);
        #2;
        check("t3_wren", 64'(bus.rf_wren), 64'd1);
        check("t3_hz_out", 64'(bus.hazard), 64'd1);
        tick();
        check("t3_hz_clear", 64'(bus.hazard), 64'd0);
        bus.rs1_addr = '0;

        // same-cycle reserve and retire of 9: reservation survives
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd9;
        tick();
        set_req(0, 1'b1, 5'd9, 32'h99);
        bus.rs2_addr = 5'd9;
        #2 check("t4_ready", 64'(bus.req_ready), 64'b01);
        tick();
        bus.rsv_valid = 1'b0;
        set_req(0, 1'b0, 5'd9, 32'h99);
        #2 check("t4_hz0", 64'(bus.hazard), 64'd1);
        tick();
        check("t4_hz1", 64'(bus.hazard), 64'd1);
        tick();
        check("t4_hz2", 64'(bus.hazard), 64'd1);
        set_req(0, 1'b1, 5'd9, 32'h98);
        tick();
        set_req(0, 1'b0, 5'd9, 32'h98);
        tick();
        #2 check("t4_hz_gone", 64'(bus.hazard), 64'd0);
        bus.rs2_addr = '0;

        // writes and reservations of x0
        tick();
        set_req(0, 1'b1, 5'd0, 32'h1234);
        #2 check("t5_ready", 64'(bus.req_ready), 64'b01);
        tick();
        set_req(0, 1'b0, 5'd0, 32'h1234);
        #2 check("t5_wren", 64'(bus.rf_wren), 64'd0);
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd0;
        tick();
        bus.rsv_valid = 1'b0;
        bus.rs1_addr  = 5'd0;
        #2 check("t5_hz_x0", 64'(bus.hazard), 64'd0);

        // reset in the middle of traffic
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd3;
        tick();
        bus.rsv_valid = 1'b0;
        set_req(0, 1'b1, 5'd12, 32'hC0FFEE);
        tick();
        set_req(0, 1'b0, 5'd12, 32'hC0FFEE);
        bus.rs1_addr = 5'd3;
        #1;
        check("t6_pre_wren", 64'(bus.rf_wren), 64'd1);
        check("t6_pre_hz",   64'(bus.hazard),  64'd1);
        rst = 1'b0;
        #1;
        check("t6_wren",  64'(bus.rf_wren),  64'd0);
        check("t6_waddr", 64'(bus.rf_waddr), 64'd0);
        check("t6_wdata", 64'(bus.rf_wdata), 64'd0);
        check("t6_hz",    64'(bus.hazard),   64'd0);
        tick();
        rst = 1'b1;
        bus.req_valid = 2'b10;
        #1 check("t6_req1_only", 64'(bus.req_ready), 64'b10);
        bus.req_valid = 2'b11;
        #1 check("t6_req0_first", 64'(bus.req_ready), 64'b01);
        bus.req_valid = '0;
        bus.rs1_addr  = '0;
        tick();

        // randomized traffic, requesters hold their request until it transfers
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || m_last_g == i)
                    set_req(i, ($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)), $urandom);
            end
            bus.rsv_valid = ($urandom_range(0, 3) == 0);
            bus.rsv_addr  = AW'($urandom_range(0, 7));
            bus.rs1_addr  = AW'($urandom_range(0, 7));
            bus.rs2_addr  = AW'($urandom_range(0, 7));
            tick();
        end

        bus.req_valid = '0;
        bus.rsv_valid = 1'b0;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
